variable_delay_line: RTL and testbench
======================================

VARIABLE_DELAY_LINE -- requirements
Module: variable_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data bits carried per sample.
REQ-002 Parameter MAX_DELAY, default 16, largest supported delay in cycles, SHALL be >= 2.
REQ-003 Parameter DEFAULT_DELAY, default 4, delay in force after reset, SHALL be in 1..MAX_DELAY.
REQ-004 clk_in  input  1  sole clock; all state on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  sample qualifier, sampled every cycle.
REQ-007 in_data  input  WIDTH  sample payload.
REQ-008 delay_in  input  clog2(MAX_DELAY+1)  requested delay in cycles.
REQ-009 delay_load  input  1  one-cycle strobe; latch delay_in as new delay.
REQ-010 out_valid  output  1  in_valid delayed by current delay, gated by priming.
REQ-011 out_data  output  WIDTH  in_data delayed by current delay.
REQ-012 primed  output  1  high when output reflects the current delay setting.
REQ-013 cur_delay  output  clog2(MAX_DELAY+1)  delay currently in force.

Function
REQ-014 Block SHALL behave as a runtime-programmable fixed-latency delay: {in_valid,in_data} sampled at edge t SHALL appear on {out_valid,out_data} immediately after edge t+D, D = cur_delay.
REQ-015 Storage SHALL be a circular buffer of MAX_DELAY entries with a write pointer advancing every cycle, wrapping MAX_DELAY-1 -> 0, independent of in_valid.
REQ-016 Read slot SHALL be (wr_ptr - D) modulo MAX_DELAY; out_data and out_valid SHALL be registered.
REQ-017 delay_in = 0 SHALL load D = 1; delay_in > MAX_DELAY SHALL load D = MAX_DELAY.
REQ-018 State machine: FILL, RUN; FILL counts fill_cnt 0..D-1 with primed=0 and out_valid forced 0; on fill_cnt = D-1 go to RUN at next edge; RUN holds primed=1.
REQ-019 delay_load in any state SHALL update cur_delay at that edge, clear fill_cnt, enter FILL; buffer contents are not cleared.
REQ-020 delay_load asserted on the final FILL cycle SHALL win: stay in FILL with new D, fill_cnt = 0.
REQ-021 delay_load with delay_in equal to cur_delay SHALL still restart FILL.
REQ-022 out_data in FILL is don't-care but SHALL be driven (no X from uninitialised storage is permitted to reach out_valid).
REQ-023 Samples entering during FILL SHALL still be written and emerge D cycles later once primed.

Reset
REQ-024 rst_in high SHALL immediately set out_valid=0, out_data=0, primed=0, wr_ptr=0, fill_cnt=0, cur_delay=DEFAULT_DELAY, state FILL.
REQ-025 Buffer contents need not reset; valid bits of every entry SHALL reset to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; none SHALL appear after reset deassertion.
REQ-027 First edge after deassertion SHALL be treated as FILL cycle 0.

Configuration
REQ-028 Macro VDL_DROP_COUNT_EN defined: add output drop_count (16 bits), incremented (saturating at 0xFFFF) per valid in-flight sample lost by delay_load, i.e. buffered valid samples not yet output whose slot is abandoned; reset to 0.
REQ-029 Macro undefined: no drop_count port, no counter logic; all other behaviour identical.

Verification
REQ-030 Reset, D=4 default; in_valid=1 in_data=0xA5 at cycle 10 only -> out_valid=1 out_data=0xA5 at cycle 14 only; primed=1 from cycle 4.
REQ-031 delay_load delay_in=16 (MAX) then stream 0..31 continuous valid -> primed after 16 cycles; out_data sequence 0..31 each exactly 16 cycles late, wrap seamless.
REQ-032 delay_in=0 -> cur_delay=1, 1-cycle latency; delay_in=20 -> cur_delay=16.
REQ-033 D=8 streaming, delay_load delay_in=3 mid-stream -> primed low 3 cycles, then samples 3-cycles late; with VDL_DROP_COUNT_EN drop_count equals in-flight valids abandoned (5).
REQ-034 Assert rst_in for 1 cycle while 4 valid samples in flight -> out_valid stays 0 until new samples pass, cur_delay=4.
REQ-035 delay_load on final FILL cycle -> FILL restarts, primed stays 0 for full new D cycles.

Source files
------------

// File: rtl/variable_delay_line.sv
// Runtime-programmable fixed-latency delay built on a circular buffer with a FILL/RUN priming FSM.
// Optional feature macro VDL_DROP_COUNT_EN adds a saturating drop_count of in-flight samples abandoned by delay_load.
module variable_delay_line #(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               in_valid,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic [$clog2(MAX_DELAY+1)-1:0]     delay_in,
  input  logic                               delay_load,
  output logic                               out_valid,
  output logic [WIDTH-1:0]                   out_data,
  output logic                               primed,
  output logic [$clog2(MAX_DELAY+1)-1:0]     cur_delay
`ifdef VDL_DROP_COUNT_EN
  ,
  output logic [15:0]                        drop_count
`endif
);

  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int PW = $clog2(MAX_DELAY);
  localparam logic [DW-1:0] MAX_D     = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEF_D     = DW'(DEFAULT_DELAY);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_DELAY - 1);
  localparam logic [DW:0]   DEPTH_X   = (DW+1)'(MAX_DELAY);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] req);
    logic [DW-1:0] res;
    if (req == '0) begin
      res = DW'(1);
    end else if (req > MAX_D) begin
      res = MAX_D;
    end else begin
      res = req;
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [DW-1:0]        cur_delay_q, cur_delay_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [MAX_DELAY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]     mem_q [MAX_DELAY];
  logic [DW:0]          rd_sum_s;
  logic [PW-1:0]        rd_slot_s;

  // Read slot trails the write pointer by the delay in force, modulo buffer depth.
  always_comb begin
    rd_sum_s = (DW+1)'(wr_ptr_q) + DEPTH_X - {1'b0, cur_delay_q};
    if (rd_sum_s >= DEPTH_X) begin
      rd_slot_s = PW'(rd_sum_s - DEPTH_X);
    end else begin
      rd_slot_s = PW'(rd_sum_s);
    end
  end

  // Next-state: pointer advance, valid-bit write, FILL/RUN sequencing and gated output data.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    cur_delay_d = cur_delay_q;
    wr_ptr_d    = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
    vld_d       = vld_q;
    vld_d[wr_ptr_q] = in_valid;

    if (delay_load) begin
      // A reload always restarts priming, even on the final FILL cycle or with an unchanged delay.
      cur_delay_d = clamp_delay(delay_in);
      fill_cnt_d  = '0;
      state_d     = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (fill_cnt_q == cur_delay_q - DW'(1)) begin
            state_d    = ST_RUN;
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + DW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      endcase
    end

    if (state_d == ST_RUN) begin
      out_valid_d = vld_q[rd_slot_s];
      out_data_d  = mem_q[rd_slot_s];
    end else begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  // Control state, valid bits and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      cur_delay_q <= DEF_D;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      cur_delay_q <= cur_delay_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Payload storage; written every cycle, contents never need a reset.
  always_ff @(posedge clk_in) begin
    mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = (state_q == ST_RUN);
  assign cur_delay = cur_delay_q;

`ifdef VDL_DROP_COUNT_EN
  function automatic logic [PW-1:0] slot_at_age(input logic [PW-1:0] ptr, input int age);
    int idx;
    idx = int'(ptr) - age;
    if (idx < 0) begin
      idx = idx + MAX_DELAY;
    end else begin
      idx = idx;
    end
    return PW'(idx);
  endfunction

  logic [15:0]   drop_q, drop_d, drop_inc_s;
  logic [16:0]   drop_sum_s;
  logic [DW-1:0] new_delay_s;

  // Samples aged between the new and the old delay at a reload are skipped by the new read slot.
  always_comb begin
    new_delay_s = clamp_delay(delay_in);
    drop_inc_s  = 16'd0;
    for (int a = 1; a < MAX_DELAY; a++) begin
      if (delay_load && (a >= int'(new_delay_s)) && (a < int'(cur_delay_q)) &&
          ((state_q == ST_RUN) || (a <= int'(fill_cnt_q) + 1)) &&
          vld_q[slot_at_age(wr_ptr_q, a)]) begin
        drop_inc_s = drop_inc_s + 16'd1;
      end else begin
        drop_inc_s = drop_inc_s;
      end
    end
    drop_sum_s = {1'b0, drop_q} + {1'b0, drop_inc_s};
    if (drop_sum_s[16]) begin
      drop_d = 16'hFFFF;
    end else begin
      drop_d = drop_sum_s[15:0];
    end
  end

  // Saturating drop counter register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_q <= 16'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_variable_delay_line.sv
// Self-checking bench: an edge-indexed sample history model predicts every output, plus literal spot checks.
module tb_variable_delay_line;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [4:0] delay_in = 5'd0;
  logic       delay_load = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       primed;
  logic [4:0] cur_delay;
`ifdef VDL_DROP_COUNT_EN
  logic [15:0] drop_count;
  logic [15:0] drop_base;
`endif

  variable_delay_line #(.WIDTH(8), .MAX_DELAY(16), .DEFAULT_DELAY(4)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .delay_in   (delay_in),
    .delay_load (delay_load),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .primed     (primed),
    .cur_delay  (cur_delay)
`ifdef VDL_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int failed = 0;

  // Model: history of samples by edge number; origin = edge of last reload (reset counts as the edge before the first).
  int         n = 1;
  int         origin = 0;
  int         md = 4;
  bit         hv [0:4095];
  logic [7:0] hd [0:4095];
  bit         chk_en = 1'b0;
  bit         exp_valid = 1'b0;
  bit         exp_primed = 1'b0;
  logic [7:0] exp_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit ld, input logic [4:0] dl);
    int dv;
    hv[n] = v;
    hd[n] = d;
    if (ld) begin
      dv = int'(dl);
      origin = n;
      md = (dv == 0) ? 1 : ((dv > 16) ? 16 : dv);
    end
    exp_primed = (n >= origin + md);
    exp_valid  = exp_primed && hv[n - md];
    exp_data   = exp_valid ? hd[n - md] : 8'd0;
    n++;
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit ld, input logic [4:0] dl);
    @(negedge clk_in);
    rst_in = 1'b0;
    in_valid = v;
    in_data = d;
    delay_load = ld;
    delay_in = dl;
    @(posedge clk_in);
    #1;
    model_edge(v, d, ld, dl);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    in_valid = 1'b0;
    delay_load = 1'b0;
    in_data = 8'd0;
    delay_in = 5'd0;
    exp_valid = 1'b0;
    exp_primed = 1'b0;
    md = 4;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
    check("rst_cur_delay", 32'(cur_delay), 32'd4);
`ifdef VDL_DROP_COUNT_EN
    check("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    @(posedge clk_in);
    #1;
    origin = n - 1;
    hv[n - 1] = 1'b0;
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("primed", 32'(primed), 32'(exp_primed));
      check("cur_delay", 32'(cur_delay), 32'(md));
      if (exp_valid) check("out_data", 32'(out_data), 32'(exp_data));
    end
  end

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Default D=4: single sample 0xA5 at edge 10 emerges after edge 14 only; primed after edge 3.
    for (int k = 0; k < 20; k++) begin
      cyc(k == 10, (k == 10) ? 8'hA5 : 8'(k), 1'b0, 5'd0);
      if (k == 2) check("fill_d4", 32'(primed), 32'd0);
      if (k == 3) check("prime_d4", 32'(primed), 32'd1);
      if (k == 13 || k == 15) check("a5_once", 32'(out_valid), 32'd0);
      if (k == 14) begin
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
      end
    end

    // delay_in=0 clamps to 1 with single-cycle latency; delay_in=20 clamps to 16.
    cyc(1'b0, 8'h00, 1'b1, 5'd0);
    check("clamp_lo", 32'(cur_delay), 32'd1);
    check("d1_fill", 32'(primed), 32'd0);
    cyc(1'b1, 8'h3C, 1'b0, 5'd0);
    check("d1_prime", 32'(primed), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 5'd0);
    check("d1_lat_valid", 32'(out_valid), 32'd1);
    check("d1_lat_data", 32'(out_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 5'd20);
    check("clamp_hi", 32'(cur_delay), 32'd16);

    // D=16 (full depth): stream 0..31, each exactly 16 cycles late across the wrap.
    for (int j = 1; j <= 50; j++) begin
      cyc(j <= 32, 8'(j - 1), 1'b0, 5'd0);
      if (j == 15) check("d16_fill", 32'(primed), 32'd0);
      if (j == 16) check("d16_prime", 32'(primed), 32'd1);
      if (j >= 17 && j <= 48) begin
        check("d16_valid", 32'(out_valid), 32'd1);
        check("d16_seq", 32'(out_data), 32'(j - 17));
      end
    end

    // D=8 streaming, mid-stream reload to 3: primed low exactly 3 cycles.
    cyc(1'b0, 8'h00, 1'b1, 5'd8);
`ifdef VDL_DROP_COUNT_EN
    drop_base = drop_count;
`endif
    for (int j = 1; j <= 40; j++) begin
      cyc(1'b1, 8'(100 + j), j == 20, 5'd3);
      if (j >= 20 && j <= 22) check("d3_refill", 32'(primed), 32'd0);
      if (j == 19 || j == 23) check("d3_primed", 32'(primed), 32'd1);
      if (j == 23) check("d3_first", 32'(out_data), 32'd120);
`ifdef VDL_DROP_COUNT_EN
      if (j == 20) check("drop5", 32'(drop_count - drop_base), 32'd5);
`endif
    end

    // Reload on the final FILL cycle wins: priming restarts for the full new delay.
    cyc(1'b0, 8'h00, 1'b1, 5'd6);
    for (int j = 1; j <= 14; j++) begin
      cyc(1'b1, 8'(j * 7), j == 6, 5'd5);
      if (j <= 10) check("late_load_fill", 32'(primed), 32'd0);
      if (j == 11) begin
        check("late_load_prime", 32'(primed), 32'd1);
        check("late_load_data", 32'(out_data), 32'd42);
      end
    end

    // Reset with 4 valid samples in flight: none may emerge afterwards.
    cyc(1'b0, 8'h00, 1'b1, 5'd4);
    for (int j = 1; j <= 4; j++) cyc(1'b1, 8'(200 + j), 1'b0, 5'd0);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(k == 6, 8'h5A, 1'b0, 5'd0);
      if (k == 0) check("post_rst_delay", 32'(cur_delay), 32'd4);
      if (k < 10) check("post_rst_quiet", 32'(out_valid), 32'd0);
      if (k == 10) begin
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'h5A);
      end
    end

    // Mixed traffic with occasional reloads, including out-of-range and repeated delays.
    for (int k = 0; k < 300; k++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 22) == 0), 5'($urandom_range(0, 23)));
    end

    @(negedge clk_in);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
